// File: rtl/irq_ctrl.sv
// irq_ctrl: word-addressed interrupt controller; per-source level/edge capture, pending and mask state.
// Latency: irq_in -> HWInt/IRQ one clock edge (three edges with IRQ_CTRL_SYNC_EN); Dout is combinational.
// Backpressure: none; register accesses complete in a single cycle and the block never stalls the Bridge.
//
// Optional feature macro: IRQ_CTRL_SYNC_EN
//   defined   -> every irq_in bit passes through a 2-flop synchronizer before sampling
//   undefined -> irq_in is sampled directly (no synchronizer flops)
//
// Ports:
//   clk     system clock
//   reset   asynchronous active-low reset (0 = reset)
//   Addr    word address [31:2]; only Addr[3:2] is decoded
//   WE      word write strobe from the Bridge
//   Din     write data
//   Dout    read data of the addressed register (combinational)
//   irq_in  raw source lines (bit 0 = TC0, bit 1 = TC1, bit 2 = external)
//   HWInt   masked pending vector to the CPU
//   IRQ     OR of HWInt
//
// Register map (Addr[3:2]); bits at and above N_SRC read 0 and ignore writes:
//   0 PEND  pending; write-1-to-clear affects edge-mode bits only
//   1 MASK  1 = source enabled onto HWInt
//   2 MODE  1 = edge-triggered, 0 = level
//   3 RAW   sampled inputs, read-only
module irq_ctrl #(
  parameter int N_SRC    = 6,
  parameter int BASE_OFS = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:2]       Addr,
  input  logic              WE,
  input  logic [31:0]       Din,
  output logic [31:0]       Dout,
  input  logic [N_SRC-1:0]  irq_in,
  output logic [N_SRC-1:0]  HWInt,
  output logic              IRQ
);

  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_MODE = 2'd2;
  localparam logic [1:0] A_RAW  = 2'd3;

  logic [N_SRC-1:0] s_in;
  logic [N_SRC-1:0] s_prev;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] pend_nxt;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] mode;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] w1c;

  // Only Addr[3:2] and the low N_SRC data bits matter; BASE_OFS is
  // placement documentation for the Bridge window.
  logic unused_bits;
  assign unused_bits = ^{Addr[31:4], Din[31:N_SRC], BASE_OFS[0]};

`ifdef IRQ_CTRL_SYNC_EN
  logic [N_SRC-1:0] sync_q1;
  logic [N_SRC-1:0] sync_q2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_in;
      sync_q2 <= sync_q1;
    end
  end

  assign s_in = sync_q2;
`else
  assign s_in = irq_in;
`endif

  assign rise = s_in & ~s_prev;
  assign w1c  = (WE && (Addr[3:2] == A_PEND)) ? Din[N_SRC-1:0] : '0;

  // Pending update uses the MODE value in force before this edge, so a
  // write to MODE changes capture behaviour from the following edge on.
  // In edge mode a fresh rising edge beats a same-cycle W1C.
  always_comb begin
    pend_nxt = pend;
    for (int i = 0; i < N_SRC; i++) begin
      if (!mode[i]) begin
        pend_nxt[i] = s_in[i];
      end else if (rise[i]) begin
        pend_nxt[i] = 1'b1;
      end else if (w1c[i]) begin
        pend_nxt[i] = 1'b0;
      end
    end
  end

  // s_prev resets to 0, so a line already high at reset release is seen
  // as a rising edge on the first clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_prev <= '0;
      pend   <= '0;
      mask   <= '0;
      mode   <= '0;
    end else begin
      s_prev <= s_in;
      pend   <= pend_nxt;
      if (WE && (Addr[3:2] == A_MASK)) begin
        mask <= Din[N_SRC-1:0];
      end
      if (WE && (Addr[3:2] == A_MODE)) begin
        mode <= Din[N_SRC-1:0];
      end
    end
  end

  // Outputs come from registers only; irq_in never reaches HWInt
  // without passing through PEND.
  assign HWInt = pend & mask;
  assign IRQ   = |HWInt;

  always_comb begin
    Dout = '0;
    case (Addr[3:2])
      A_PEND:  Dout[N_SRC-1:0] = pend;
      A_MASK:  Dout[N_SRC-1:0] = mask;
      A_MODE:  Dout[N_SRC-1:0] = mode;
      A_RAW:   Dout[N_SRC-1:0] = s_in;
      default: Dout = '0;
    endcase
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller between the raw device IRQ lines (TC0, TC1, external `interrupt`) and the CPU's HWInt input.
- Captures each source as level- or edge-triggered, holds per-source pending and mask state, and presents the masked pending vector as HWInt.
- Software programs it through the Bridge as one more word-addressed peripheral, alongside the timers.

Parameters:
- N_SRC, 6, number of interrupt sources; equals HWInt width.
- BASE_OFS, 0, reserved word-offset base within the Bridge window; unused internally, documentation only.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- Addr  input  30  word address [31:2]; only Addr[3:2] decoded
- WE  input  1  write strobe from Bridge, word write
- Din  input  32  write data
- Dout  output  32  read data for addressed register (combinational)
- irq_in  input  N_SRC  raw source lines, bit 0 = TC0, bit 1 = TC1, bit 2 = external
- HWInt  output  N_SRC  masked pending vector to CPU
- IRQ  output  1  OR-reduction of HWInt

Behaviour:
- Register map, selected by Addr[3:2]; bits above N_SRC read 0 and ignore writes.
  - 0 PEND: read returns pending. Write-1-to-clear applies to edge-mode bits only.
  - 1 MASK: read/write, 1 = enabled.
  - 2 MODE: read/write, 1 = edge, 0 = level.
  - 3 RAW: read-only sampled inputs `s_in`. Writes are ignored.
- Reset (asynchronous, reset = 0):
  - PEND, MASK, MODE, `s_prev` and any synchronizer flops go to 0.
  - HWInt = 0, IRQ = 0. Dout follows Addr combinationally.
- Sampling: `s_in` = irq_in directly (see Optional Feature). `s_prev` <= `s_in` every cycle.
- Level bit i: PEND[i] <= s_in[i] every cycle. W1C has no effect.
- Edge bit i: set when `s_in[i] & ~s_prev[i]`. Cleared by a write to PEND with Din[i] = 1. Otherwise holds.
- Simultaneous rising edge and W1C on the same bit in the same cycle: set wins, PEND[i] = 1.
- Line already high at reset release: counts as a rising edge on the first clock, because `s_prev` resets to 0.
- Mode change:
  - Edge -> level: PEND[i] follows `s_in[i]` from the next edge.
  - Level -> edge: PEND[i] holds its current value until W1C.
- MASK affects only HWInt = PEND & MASK. Pending state is still recorded while masked. Unmasking a pending bit raises HWInt combinationally in the same cycle.
- Latency with no synchronizer: irq_in rising before edge k -> PEND set at edge k -> HWInt/IRQ high after edge k (1 cycle).
- Writes take effect at the clock edge. A read of the same address in the same cycle returns the old value.
- HWInt and IRQ are purely combinational from registers; no combinational path from irq_in.

Optional Feature:
- Macro: IRQ_CTRL_SYNC_EN.
- Defined: each irq_in bit passes through a 2-flop synchronizer (reset 0) before `s_in`. Input-to-HWInt latency becomes 3 edges, and RAW reflects the synchronized value.
- Undefined: `s_in` = irq_in. Latency is 1 edge and the flops are absent.

Test Plan:
- Reset with all irq_in = 0, then release: Dout at Addr 0..3 reads 0; HWInt = 0, IRQ = 0.
- MASK = 6'h3F, MODE = 0; pulse irq_in[0] high for 3 cycles -> PEND[0] = 1 for 3 cycles, HWInt = 6'h01, IRQ = 1 during the pulse, then 0.
- MODE = 6'h04, MASK = 6'h04; 1-cycle pulse on irq_in[2] -> PEND stays 6'h04 after the pulse. Write PEND Din = 32'h4 -> PEND = 0 and IRQ = 0 next cycle.
- Edge mode on bit 1: issue a rising edge on irq_in[1] and a W1C of bit 1 in the same cycle -> PEND[1] = 1 afterwards.
- MASK = 0; edge on bit 0 (MODE[0] = 1) -> PEND = 6'h01, HWInt = 0. Write MASK = 1 -> HWInt = 6'h01 with no new edge required.
- Assert reset = 0 while PEND = 6'h05 and MASK = 6'h3F -> HWInt = 0 immediately, without waiting for clk. With irq_in[0] held high at release, PEND[0] = 1 after the first edge.
